// File: rtl/ram_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and sizing helpers for the fake-RAM request arbiter.
//   arb_state_t      : arbiter FSM states
//   W_TIMEOUT_DEF    : default write-response timeout in cycles
//   TMO_CNT_W_DEF    : timeout counter width for the default timeout
//   tmo_cnt_width()  : counter width able to hold the value w_timeout
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR_REQ  = 3'd2,
    WR_WAIT = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

  localparam int W_TIMEOUT_DEF = 15;
  localparam int TMO_CNT_W_DEF = $clog2(W_TIMEOUT_DEF + 1);

  // Width of a counter that must be able to reach w_timeout itself.
  function automatic int tmo_cnt_width(input int w_timeout);
    return $clog2(w_timeout + 1);
  endfunction

endpackage

// File: rtl/ram_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// Bus bundles around ram_req_arbiter.
//
// ram_req_if : requester side. master = requesters, slave = arbiter.
//   req_valid  [NUM_REQ]         request, held until own resp_valid bit
//   req_wen    [NUM_REQ]         1 = write, 0 = read
//   req_addr   [NUM_REQ*WORD_W]  packed word addresses
//   req_wdata  [NUM_REQ*WORD_W]  packed write data
//   resp_valid [NUM_REQ]         one-hot one-cycle completion pulse
//   resp_err                     qualifies resp_valid
//   resp_rdata [WORD_W]          read data for a non-error read
//
// ram_mem_if : RAM side. master = arbiter, slave = RAM.
//   w_req/w_addr/w_data_in -> RAM, w_resp <- RAM one cycle after w_req
//   r_req/r_addr           -> RAM, r_data_out/r_resp <- RAM same cycle
// ---------------------------------------------------------------------------
interface ram_req_if #(
  parameter int NUM_REQ = 2,
  parameter int WORD_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_wen;
  logic [NUM_REQ*WORD_W-1:0] req_addr;
  logic [NUM_REQ*WORD_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_err;
  logic [WORD_W-1:0]         resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata,
    input  resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata,
    output resp_valid, resp_err, resp_rdata
  );
endinterface

interface ram_mem_if #(
  parameter int WORD_W = 32
);
  logic              w_req;
  logic [WORD_W-1:0] w_addr;
  logic [WORD_W-1:0] w_data_in;
  logic              w_resp;
  logic              r_req;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data_out;
  logic              r_resp;

  modport master (
    output w_req, w_addr, w_data_in, r_req, r_addr,
    input  w_resp, r_data_out, r_resp
  );

  modport slave (
    input  w_req, w_addr, w_data_in, r_req, r_addr,
    output w_resp, r_data_out, r_resp
  );
endinterface

// File: rtl/ram_req_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: the first set bit of req scanning upward
// from (last_grant+1) mod NUM_REQ, wrapping around.
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    most recently served index
//   any        out 1        at least one request is set
//   grant      out IDX_W    chosen index (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               any,
  output logic [IDX_W-1:0]   grant
);

  logic [IDX_W-1:0] idx_s;

  // Wrapped index at distance k from last_grant; NUM_REQ need not be 2^n.
  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int k);
    return IDX_W'((base + k) % NUM_REQ);
  endfunction

  // Scan candidates in priority order; the first set one wins.
  always_comb begin
    any   = 1'b0;
    grant = {IDX_W{1'b0}};
    idx_s = {IDX_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = wrap_idx(int'(last_grant), k);
      if (!any && req[idx_s]) begin
        any   = 1'b1;
        grant = idx_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/ram_req_arbiter.sv
// ---------------------------------------------------------------------------
// ram_req_arbiter
// Shares one fake-RAM read/write port between NUM_REQ requesters with a
// round-robin grant and a single outstanding transaction. Out-of-range
// addresses and stalled writes complete with resp_err=1.
//   clk, reset  clock and synchronous active-high reset
//   req_if      requester bundle (slave side)
//   mem_if      RAM bundle (master side)
//   grant_id    requester currently owned (debug)
//   busy        high whenever the FSM is not IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module ram_req_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int WORD_W    = 32,
  parameter int DRAM_SIZE = 64,
  parameter int W_TIMEOUT = W_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  ram_req_if.slave                   req_if,
  ram_mem_if.master                  mem_if,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = tmo_cnt_width(W_TIMEOUT);

  localparam logic [IDX_W-1:0]   LAST_GRANT_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0       = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0]   TMO_LIMIT      = CNT_W'(W_TIMEOUT);
  // One bit wider than the address so DRAM_SIZE = 2^WORD_W still compares.
  localparam logic [WORD_W:0]    DRAM_LIMIT     = (WORD_W + 1)'(DRAM_SIZE);

  arb_state_t         state_r;
  logic [IDX_W-1:0]   grant_id_r;
  logic [IDX_W-1:0]   last_grant_r;
  logic [WORD_W-1:0]  addr_r;
  logic [WORD_W-1:0]  wdata_r;
  logic [CNT_W-1:0]   tmo_cnt_r;
  logic               busy_r;
  logic               w_req_r;
  logic               r_req_r;
  logic [NUM_REQ-1:0] resp_valid_r;
  logic               resp_err_r;
  logic [WORD_W-1:0]  resp_rdata_r;

  logic               pick_any_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [WORD_W-1:0]  sel_addr_s;
  logic [WORD_W-1:0]  sel_wdata_s;
  logic               sel_wen_s;
  logic               addr_oor_s;
  logic [CNT_W-1:0]   tmo_inc_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_if.req_valid),
    .last_grant (last_grant_r),
    .any        (pick_any_s),
    .grant      (pick_idx_s)
  );

  // Mux the picked requester's fields and screen its address.
  always_comb begin
    sel_addr_s  = {WORD_W{1'b0}};
    sel_wdata_s = {WORD_W{1'b0}};
    sel_wen_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        sel_addr_s  = req_if.req_addr[i*WORD_W +: WORD_W];
        sel_wdata_s = req_if.req_wdata[i*WORD_W +: WORD_W];
        sel_wen_s   = req_if.req_wen[i];
      end else begin
        sel_wen_s = sel_wen_s;
      end
    end
    addr_oor_s = ({1'b0, sel_addr_s} >= DRAM_LIMIT);
    tmo_inc_s  = tmo_cnt_r + CNT_ONE;
  end

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_id_r   <= {IDX_W{1'b0}};
      last_grant_r <= LAST_GRANT_RST;
      addr_r       <= {WORD_W{1'b0}};
      wdata_r      <= {WORD_W{1'b0}};
      tmo_cnt_r    <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      w_req_r      <= 1'b0;
      r_req_r      <= 1'b0;
      resp_valid_r <= {NUM_REQ{1'b0}};
      resp_err_r   <= 1'b0;
      resp_rdata_r <= {WORD_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            grant_id_r <= pick_idx_s;
            addr_r     <= sel_addr_s;
            wdata_r    <= sel_wdata_s;
            busy_r     <= 1'b1;
            if (addr_oor_s) begin
              // Range error completes without touching the RAM.
              resp_valid_r <= ONE_HOT0 << pick_idx_s;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= {WORD_W{1'b0}};
              state_r      <= RESP;
            end else if (sel_wen_s) begin
              w_req_r <= 1'b1;
              state_r <= WR_REQ;
            end else begin
              r_req_r <= 1'b1;
              state_r <= RD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          if (mem_if.r_resp) begin
            r_req_r      <= 1'b0;
            resp_valid_r <= ONE_HOT0 << grant_id_r;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= mem_if.r_data_out;
            state_r      <= RESP;
          end else begin
            state_r <= RD;
          end
        end
        WR_REQ: begin
          w_req_r   <= 1'b0;
          tmo_cnt_r <= {CNT_W{1'b0}};
          state_r   <= WR_WAIT;
        end
        WR_WAIT: begin
          if (mem_if.w_resp) begin
            resp_valid_r <= ONE_HOT0 << grant_id_r;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {WORD_W{1'b0}};
            state_r      <= RESP;
          end else if (tmo_inc_s == TMO_LIMIT) begin
            // W_TIMEOUT cycles spent in WR_WAIT without a response.
            tmo_cnt_r    <= tmo_inc_s;
            resp_valid_r <= ONE_HOT0 << grant_id_r;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= {WORD_W{1'b0}};
            state_r      <= RESP;
          end else begin
            tmo_cnt_r <= tmo_inc_s;
            state_r   <= WR_WAIT;
          end
        end
        RESP: begin
          resp_valid_r <= {NUM_REQ{1'b0}};
          resp_err_r   <= 1'b0;
          resp_rdata_r <= {WORD_W{1'b0}};
          last_grant_r <= grant_id_r;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          w_req_r      <= 1'b0;
          r_req_r      <= 1'b0;
          resp_valid_r <= {NUM_REQ{1'b0}};
          resp_err_r   <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // RAM address/data hold their latched values; only the strobes pulse.
  assign mem_if.w_req     = w_req_r;
  assign mem_if.w_addr    = addr_r;
  assign mem_if.w_data_in = wdata_r;
  assign mem_if.r_req     = r_req_r;
  assign mem_if.r_addr    = addr_r;

  assign req_if.resp_valid = resp_valid_r;
  assign req_if.resp_err   = resp_err_r;
  assign req_if.resp_rdata = resp_rdata_r;

  assign grant_id = grant_id_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_req_arbiter
// Directed bench for ram_req_arbiter: a table of single-requester
// transactions followed by hand-written contention, write-timeout and
// reset-mid-write sequences. A small RAM stub answers reads in the same
// cycle and writes one cycle after w_req (unless hold_wresp is set).
// ---------------------------------------------------------------------------
module tb_ram_req_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int WORD_W    = 32;
  localparam int DRAM_SIZE = 64;
  localparam int W_TIMEOUT = 15;

  logic                       clk;
  logic                       reset;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       busy;

  ram_req_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) req_if();
  ram_mem_if #(.WORD_W(WORD_W)) mem_if();

  ram_req_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WORD_W    (WORD_W),
    .DRAM_SIZE (DRAM_SIZE),
    .W_TIMEOUT (W_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_if   (req_if),
    .mem_if   (mem_if),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stub
  logic [WORD_W-1:0] mem [0:DRAM_SIZE-1];
  logic              hold_wresp;
  logic              w_resp_q;

  always @(posedge clk) begin
    if (reset) begin
      w_resp_q <= 1'b0;
      for (int i = 0; i < DRAM_SIZE; i++) mem[i] <= 32'hCAFE0000 | 32'(i);
      mem[1] <= 32'h00000011;
      mem[2] <= 32'h00000022;
    end else begin
      w_resp_q <= mem_if.w_req & ~hold_wresp;
      if (mem_if.w_req && mem_if.w_addr < 32'd64) mem[mem_if.w_addr[5:0]] <= mem_if.w_data_in;
    end
  end

  assign mem_if.w_resp     = w_resp_q;
  assign mem_if.r_resp     = mem_if.r_req;
  assign mem_if.r_data_out = (mem_if.r_addr < 32'd64) ? mem[mem_if.r_addr[5:0]] : 32'h0;

  // Scoring
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Results of the last do_txn
  int                 t_lat, t_wcnt, t_rcnt;
  logic               t_done, t_err;
  logic [NUM_REQ-1:0] t_rv, t_after;
  logic [WORD_W-1:0]  t_rdata, t_waddr, t_wdata, t_raddr;

  task automatic do_txn(input int rid, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int limit);
    @(negedge clk);
    req_if.req_wen[rid]                = wen;
    req_if.req_addr[rid*WORD_W +: WORD_W]  = addr;
    req_if.req_wdata[rid*WORD_W +: WORD_W] = wdata;
    req_if.req_valid[rid]              = 1'b1;
    t_lat = 0; t_wcnt = 0; t_rcnt = 0; t_done = 1'b0; t_err = 1'b0;
    t_rv = '0; t_rdata = '0; t_waddr = '0; t_wdata = '0; t_raddr = '0;
    while (!t_done && t_lat < limit) begin
      @(negedge clk);
      t_lat++;
      if (mem_if.w_req) begin t_wcnt++; t_waddr = mem_if.w_addr; t_wdata = mem_if.w_data_in; end
      if (mem_if.r_req) begin t_rcnt++; t_raddr = mem_if.r_addr; end
      if (req_if.resp_valid != '0) begin
        t_done  = 1'b1;
        t_rv    = req_if.resp_valid;
        t_err   = req_if.resp_err;
        t_rdata = req_if.resp_rdata;
      end
    end
    req_if.req_valid[rid] = 1'b0;
    @(negedge clk);
    t_after = req_if.resp_valid;
  endtask

  typedef struct {
    int          rid;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];
  logic [NUM_REQ-1:0] exp_rv;
  logic [NUM_REQ-1:0] seen_rv;
  int n, cyc;

  initial begin
    vecs[0] = '{0, 1'b1, 32'd5,          32'hDEADBEEF, 1'b0, 32'h0,        3};
    vecs[1] = '{0, 1'b0, 32'd5,          32'h0,        1'b0, 32'hDEADBEEF, 2};
    vecs[2] = '{1, 1'b0, 32'd64,         32'h0,        1'b1, 32'h0,        1};
    vecs[3] = '{1, 1'b0, 32'd63,         32'h0,        1'b0, 32'hCAFE003F, 2};
    vecs[4] = '{1, 1'b1, 32'd63,         32'h12345678, 1'b0, 32'h0,        3};
    vecs[5] = '{0, 1'b0, 32'd63,         32'h0,        1'b0, 32'h12345678, 2};
    vecs[6] = '{0, 1'b1, 32'hFFFFFFFF,   32'h55AA55AA, 1'b1, 32'h0,        1};
    vecs[7] = '{1, 1'b1, 32'd64,         32'h0BADF00D, 1'b1, 32'h0,        1};

    reset = 1'b1; hold_wresp = 1'b0;
    req_if.req_valid = '0; req_if.req_wen = '0; req_if.req_addr = '0; req_if.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",       64'(busy), 64'h0);
    check("rst_grant_id",   64'(grant_id), 64'h0);
    check("rst_resp_valid", 64'(req_if.resp_valid), 64'h0);
    check("rst_w_req",      64'(mem_if.w_req), 64'h0);
    check("rst_r_req",      64'(mem_if.r_req), 64'h0);
    check("rst_w_addr",     64'(mem_if.w_addr), 64'h0);
    check("rst_resp_rdata", 64'(req_if.resp_rdata), 64'h0);
    reset = 1'b0;

    // Single-requester transaction table
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].rid, vecs[i].wen, vecs[i].addr, vecs[i].wdata, 40);
      exp_rv = NUM_REQ'(1) << vecs[i].rid;
      check($sformatf("v%0d_resp_valid", i), 64'(t_rv), 64'(exp_rv));
      check($sformatf("v%0d_resp_err", i),   64'(t_err), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_resp_rdata", i), 64'(t_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("v%0d_latency", i),    64'(t_lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_no_repeat", i),  64'(t_after), 64'h0);
      check($sformatf("v%0d_w_req_cycles", i), 64'(t_wcnt),
            64'((!vecs[i].exp_err && vecs[i].wen) ? 1 : 0));
      check($sformatf("v%0d_r_req_cycles", i), 64'(t_rcnt),
            64'((!vecs[i].exp_err && !vecs[i].wen) ? 1 : 0));
      if (!vecs[i].exp_err && vecs[i].wen) begin
        check($sformatf("v%0d_w_addr", i), 64'(t_waddr), 64'(vecs[i].addr));
        check($sformatf("v%0d_w_data", i), 64'(t_wdata), 64'(vecs[i].wdata));
      end
      if (!vecs[i].exp_err && !vecs[i].wen) begin
        check($sformatf("v%0d_r_addr", i), 64'(t_raddr), 64'(vecs[i].addr));
      end
    end

    // Contention: both read continuously, grants alternate 0,1,0,1
    @(negedge clk);
    req_if.req_wen   = 2'b00;
    req_if.req_addr  = {32'd2, 32'd1};
    req_if.req_valid = 2'b11;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (req_if.resp_valid != '0) begin
        exp_rv = NUM_REQ'(1) << (n % 2);
        check($sformatf("cont%0d_resp_valid", n), 64'(req_if.resp_valid), 64'(exp_rv));
        check($sformatf("cont%0d_rdata", n), 64'(req_if.resp_rdata),
              (n % 2 == 0) ? 64'h11 : 64'h22);
        check($sformatf("cont%0d_grant_id", n), 64'(grant_id), 64'(n % 2));
        check($sformatf("cont%0d_cycle", n), 64'(cyc), 64'(2 + 3 * n));
        n++;
      end
    end
    check("cont_pulses", 64'(n), 64'd4);
    req_if.req_valid = 2'b00;
    repeat (2) @(negedge clk);

    // Write timeout, then requester 1 served normally
    hold_wresp = 1'b1;
    do_txn(0, 1'b1, 32'd3, 32'hA5A5A5A5, 60);
    check("tmo_resp_valid", 64'(t_rv), 64'h1);
    check("tmo_resp_err",   64'(t_err), 64'h1);
    check("tmo_latency",    64'(t_lat), 64'(W_TIMEOUT + 2));
    check("tmo_w_req",      64'(t_wcnt), 64'h1);
    check("tmo_rdata",      64'(t_rdata), 64'h0);
    hold_wresp = 1'b0;
    do_txn(1, 1'b0, 32'd2, 32'h0, 40);
    check("post_tmo_resp_valid", 64'(t_rv), 64'h2);
    check("post_tmo_resp_err",   64'(t_err), 64'h0);
    check("post_tmo_rdata",      64'(t_rdata), 64'h22);
    check("post_tmo_latency",    64'(t_lat), 64'h2);

    // Reset during WR_WAIT
    hold_wresp = 1'b1;
    @(negedge clk);
    req_if.req_wen[0] = 1'b1;
    req_if.req_addr[31:0] = 32'd4;
    req_if.req_wdata[31:0] = 32'h77777777;
    req_if.req_valid = 2'b01;
    @(negedge clk);
    check("mid_w_req", 64'(mem_if.w_req), 64'h1);
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_resp_valid", 64'(req_if.resp_valid), 64'h0);
    check("mid_rst_busy",       64'(busy), 64'h0);
    check("mid_rst_w_req",      64'(mem_if.w_req), 64'h0);
    check("mid_rst_r_req",      64'(mem_if.r_req), 64'h0);
    check("mid_rst_w_addr",     64'(mem_if.w_addr), 64'h0);
    check("mid_rst_w_data",     64'(mem_if.w_data_in), 64'h0);
    check("mid_rst_grant_id",   64'(grant_id), 64'h0);
    check("mid_rst_resp_err",   64'(req_if.resp_err), 64'h0);
    req_if.req_valid = 2'b00;
    reset = 1'b0;
    hold_wresp = 1'b0;
    seen_rv = '0;
    repeat (3) begin
      @(negedge clk);
      seen_rv = seen_rv | req_if.resp_valid;
    end
    check("mid_rst_no_pulse", 64'(seen_rv), 64'h0);

    // Simultaneous requests after reset: requester 0 first
    req_if.req_wen   = 2'b00;
    req_if.req_addr  = {32'd2, 32'd1};
    req_if.req_valid = 2'b11;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (req_if.resp_valid != '0) begin
        exp_rv = NUM_REQ'(1) << n;
        check($sformatf("after_rst%0d_resp_valid", n), 64'(req_if.resp_valid), 64'(exp_rv));
        check($sformatf("after_rst%0d_rdata", n), 64'(req_if.resp_rdata),
              (n == 0) ? 64'h11 : 64'h22);
        n++;
      end
    end
    check("after_rst_pulses", 64'(n), 64'd2);
    req_if.req_valid = 2'b00;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_req_arbiter.md
Name: ram_req_arbiter

Overview:
- Shares one fake-RAM read/write handshake port between NUM_REQ requesters, e.g. instruction fetch and load/store in the tb core harness.
- Round-robin grant, one outstanding RAM transaction at a time.
- Returns read data or write completion to the granted requester as a one-cycle response pulse.
- Screens out-of-range addresses and times out stalled writes with an error response.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- WORD_W, 32, address/data width, matches the RAM.
- DRAM_SIZE, 64, number of RAM words; valid addresses are 0..DRAM_SIZE-1.
- W_TIMEOUT, 15, maximum cycles spent waiting for w_resp before an error response.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request; held with its fields until that requester's resp_valid bit
- req_wen  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*WORD_W  packed word addresses, requester i in bits [i*WORD_W +: WORD_W]
- req_wdata  in  NUM_REQ*WORD_W  packed write data
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: out-of-range address or write timeout
- resp_rdata  out  WORD_W  read data, valid with resp_valid for a non-error read
- grant_id  out  $clog2(NUM_REQ)  requester currently owned (debug)
- busy  out  1  high in every state except IDLE
- w_req  out  1  to RAM
- w_addr  out  WORD_W  to RAM
- w_data_in  out  WORD_W  to RAM
- w_resp  in  1  from RAM, arrives one cycle after w_req
- r_req  out  1  to RAM
- r_addr  out  WORD_W  to RAM
- r_data_out  in  WORD_W  from RAM, combinational
- r_resp  in  1  from RAM, same cycle as r_req

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0; latched addr/data/wen 0; grant_id 0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts it with no response pulse; w_req/r_req drop the cycle after reset is sampled.
- FSM states: IDLE, RD, WR_REQ, WR_WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch grant_id, addr, wdata, wen.
  - If addr >= DRAM_SIZE: set err, go to RESP with no RAM access.
  - Else go to RD (wen=0) or WR_REQ (wen=1).
- RD (1 cycle): r_req=1, r_addr=latched addr. Register r_data_out into resp_rdata when r_resp=1. Go to RESP. If r_resp=0, stay in RD.
- WR_REQ (1 cycle): w_req=1, w_addr and w_data_in from the latched values. Go to WR_WAIT and clear the timeout counter.
- WR_WAIT: w_req=0.
  - If w_resp=1, go to RESP with err=0.
  - Else increment the counter; when it reaches W_TIMEOUT, go to RESP with err=1.
- RESP (1 cycle):
  - resp_valid[grant_id]=1 and resp_err=err.
  - resp_rdata holds the read value; it is 0 for writes and errors.
  - last_grant<=grant_id. Go to IDLE.
- RAM-side addr/data outputs hold their latched values outside RD/WR_REQ; only req strobes are gated.
- Latency from req_valid sampled in IDLE to resp_valid: read 2 cycles, write 3 cycles, range error 1 cycle.
- Back-to-back throughput: one transaction per 3 (read) or 4 (write) cycles.
- A requester whose req_valid drops before grant is simply not picked. Dropping after grant is illegal and is not checked in RTL.
- Address compare is full WORD_W unsigned; DRAM_SIZE is not required to be a power of two.

Decomposition:
- Package ram_arb_pkg:
  - arb_state_t enum (IDLE, RD, WR_REQ, WR_WAIT, RESP).
  - Timeout counter width localparam = $clog2(W_TIMEOUT+1).
- Sub-module rr_pick:
  - Parameter NUM_REQ.
  - Inputs req vector and last_grant; outputs any and grant index.
  - Combinational masked-priority pick, reusable by later tb arbiters.

Test Plan:
- Write then read, same requester: req0 writes addr 5 = 0xDEADBEEF → w_req exactly 1 cycle with w_addr=5, resp_valid[0] 3 cycles after sampling, err=0. Req0 then reads addr 5 → r_req 1 cycle, resp_valid[0] 2 cycles later, resp_rdata=0xDEADBEEF.
- Contention: req0 and req1 both read continuously from reset (addrs 1 and 2 preloaded to 0x11 and 0x22) → grants 0,1,0,1. Each requester receives its own value; no double pulse.
- Range error: req1 reads addr 64 with DRAM_SIZE=64 → resp_valid[1] and resp_err=1 one cycle after sampling. No r_req/w_req asserted; addr 63 succeeds.
- Write timeout: RAM stub holds w_resp=0, req0 writes addr 3 → resp_valid[0] with resp_err=1 exactly W_TIMEOUT+1 cycles after WR_REQ. Arbiter then serves req1 normally.
- Reset mid-write: assert reset during WR_WAIT → next cycle all outputs 0, busy=0, no resp pulse. After release, simultaneous req0/req1 grant req0 first.
